// File: rtl/seg7_pkg.sv
// Shared types, idle levels and the hex-to-seven-segment table used by the
// multiplexed display driver.
package seg7_pkg;

  // Selects one of the four display digits; digit 0 is the rightmost.
  typedef logic [1:0] digit_idx_t;

  localparam int NUM_DIGITS = 4;

  // Idle levels, active-high before any board polarity is applied.
  localparam logic [7:0] SEG_OFF = 8'h00;
  localparam logic [3:0] AN_OFF  = 4'h0;

  // Segment pattern {g,f,e,d,c,b,a} for a hex nibble, active-high.
  function automatic logic [6:0] hex7(input logic [3:0] nibble);
    logic [6:0] pattern;
    case (nibble)
      4'h0:    pattern = 7'h3F;
      4'h1:    pattern = 7'h06;
      4'h2:    pattern = 7'h5B;
      4'h3:    pattern = 7'h4F;
      4'h4:    pattern = 7'h66;
      4'h5:    pattern = 7'h6D;
      4'h6:    pattern = 7'h7D;
      4'h7:    pattern = 7'h07;
      4'h8:    pattern = 7'h7F;
      4'h9:    pattern = 7'h6F;
      4'hA:    pattern = 7'h77;
      4'hB:    pattern = 7'h7C;
      4'hC:    pattern = 7'h39;
      4'hD:    pattern = 7'h5E;
      4'hE:    pattern = 7'h79;
      default: pattern = 7'h71;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to seven-segment decoder, active-high segments.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex7(nibble_i);

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment scan driver. New data is written into a
// shadow register and copied into the displayed (active) register only at a
// frame boundary, so a frame never mixes old and new digits. The first
// DEAD_CYCLES of every digit period keep all anodes off to suppress ghosting.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned DIV_BITS    = 16,
  parameter int unsigned DEAD_CYCLES = 64,
  parameter bit          SEG_ACT_LOW = 1'b1,
  parameter bit          AN_ACT_LOW  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic [3:0]  wr_dp,
  input  logic [3:0]  wr_blank,
  output logic        pending,
  output logic        frame_tk,
  output logic [7:0]  seg,
  output logic [3:0]  an
);

  localparam logic [7:0]          SEG_POL    = SEG_ACT_LOW ? 8'hFF : 8'h00;
  localparam logic [3:0]          AN_POL     = AN_ACT_LOW  ? 4'hF  : 4'h0;
  localparam logic [7:0]          SEG_IDLE   = SEG_OFF ^ SEG_POL;
  localparam logic [3:0]          AN_IDLE    = AN_OFF  ^ AN_POL;
  localparam logic [DIV_BITS-1:0] PRESC_MAX  = '1;
  localparam logic [DIV_BITS-1:0] DEAD_LIMIT = DIV_BITS'(DEAD_CYCLES);

  logic [DIV_BITS-1:0] presc_q, presc_d;
  digit_idx_t          idx_q, idx_d;

  logic [15:0] shadow_data_q, shadow_data_d;
  logic [3:0]  shadow_dp_q, shadow_dp_d;
  logic [3:0]  shadow_blank_q, shadow_blank_d;
  logic [15:0] active_data_q, active_data_d;
  logic [3:0]  active_dp_q, active_dp_d;
  logic [3:0]  active_blank_q, active_blank_d;
  logic        pending_q, pending_d;
  logic        frame_tk_q, frame_tk_d;
  logic [7:0]  seg_q, seg_d;
  logic [3:0]  an_q, an_d;

  logic       tick;
  logic       boundary;
  logic [3:0] cur_nibble;
  logic [6:0] cur_pattern;

  assign tick       = (presc_q == PRESC_MAX);
  assign boundary   = tick && (idx_q == digit_idx_t'(NUM_DIGITS - 1));
  assign cur_nibble = active_data_q[{idx_q, 2'b00} +: 4];

  seg7_hex_decode u_decode (
    .nibble_i (cur_nibble),
    .seg_o    (cur_pattern)
  );

  // Next-state logic: scan counters, double buffer hand-over, output pattern.
  always_comb begin
    presc_d        = presc_q + DIV_BITS'(1);
    idx_d          = idx_q;
    shadow_data_d  = shadow_data_q;
    shadow_dp_d    = shadow_dp_q;
    shadow_blank_d = shadow_blank_q;
    active_data_d  = active_data_q;
    active_dp_d    = active_dp_q;
    active_blank_d = active_blank_q;
    pending_d      = pending_q;
    frame_tk_d     = boundary;
    seg_d          = SEG_IDLE;
    an_d           = AN_IDLE;

    if (tick) begin
      idx_d = idx_q + 2'd1;
    end

    // The hand-over uses the pre-edge shadow, so a write landing on the same
    // edge waits in the shadow for the following frame.
    if (boundary && pending_q) begin
      active_data_d  = shadow_data_q;
      active_dp_d    = shadow_dp_q;
      active_blank_d = shadow_blank_q;
      pending_d      = 1'b0;
    end

    if (wr_en) begin
      shadow_data_d  = wr_data;
      shadow_dp_d    = wr_dp;
      shadow_blank_d = wr_blank;
      pending_d      = 1'b1;
    end

    if ((presc_q >= DEAD_LIMIT) && !active_blank_q[idx_q]) begin
      seg_d = {active_dp_q[idx_q], cur_pattern} ^ SEG_POL;
      an_d  = (4'b0001 << idx_q) ^ AN_POL;
    end
  end

  // State and output registers; reset forces the display dark immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q        <= '0;
      idx_q          <= '0;
      shadow_data_q  <= '0;
      shadow_dp_q    <= '0;
      shadow_blank_q <= 4'hF;
      active_data_q  <= '0;
      active_dp_q    <= '0;
      active_blank_q <= 4'hF;
      pending_q      <= 1'b0;
      frame_tk_q     <= 1'b0;
      seg_q          <= SEG_IDLE;
      an_q           <= AN_IDLE;
    end else begin
      presc_q        <= presc_d;
      idx_q          <= idx_d;
      shadow_data_q  <= shadow_data_d;
      shadow_dp_q    <= shadow_dp_d;
      shadow_blank_q <= shadow_blank_d;
      active_data_q  <= active_data_d;
      active_dp_q    <= active_dp_d;
      active_blank_q <= active_blank_d;
      pending_q      <= pending_d;
      frame_tk_q     <= frame_tk_d;
      seg_q          <= seg_d;
      an_q           <= an_d;
    end
  end

  assign pending  = pending_q;
  assign frame_tk = frame_tk_q;
  assign seg      = seg_q;
  assign an       = an_q;

endmodule
